// File: rtl/fifo_wr_arbiter.sv
// Arbitrates four byte requesters onto one shared FIFO write port.
// Grants rotate round-robin, each grant lasts at most MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  valid,
  input  logic [31:0] data_bus,
  output logic [3:0]  ready,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [7:0]  din,
  output logic [3:0]  grant,
  output logic [15:0] wr_count
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BEAT_W = 5;
  localparam int unsigned CNT_W  = 16;

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be in 1..16");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               owner_valid;
  logic               xfer;
  logic               burst_done;
  logic [IDX_W-1:0]   pick;
  logic               pick_found;
  logic [IDX_W-1:0]   cand;

  // Round-robin search starting just after the last owner
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = last_q + IDX_W'(i);
      if (!pick_found && valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // Write path is combinational from the registered owner so a stall costs no cycle
  assign owner_valid = valid[owner_q];
  assign xfer        = (state_q == BURST) && owner_valid && !fifo_full;
  assign burst_done  = xfer && (beats_q == BEAT_W'(MAX_BURST - 1));

  assign ready    = xfer ? grant_q : '0;
  assign wr_en    = xfer;
  assign din      = xfer ? data_bus[{owner_q, 3'b000} +: BYTE_W] : '0;
  assign grant    = grant_q;
  assign wr_count = cnt_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    beats_d = beats_q;
    cnt_d   = xfer ? cnt_q + CNT_W'(1) : cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BURST;
          owner_d = pick;
          grant_d = N_REQ'(1) << pick;
          beats_d = '0;
        end
      end
      BURST: begin
        // Dropping valid forfeits the rest of the burst
        if (!owner_valid || burst_done) begin
          state_d = IDLE;
          last_d  = owner_q;
          beats_d = '0;
          grant_d = '0;
        end else if (xfer) begin
          beats_d = beats_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        beats_d = '0;
      end
    endcase
  end

  // Reset leaves requester 0 with first priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector tables plus reset and counter-wrap sequences.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  valid;
  logic [31:0] data_bus;
  logic        fifo_full;
  logic [3:0]  ready;
  logic        wr_en;
  logic [7:0]  din;
  logic [3:0]  grant;
  logic [15:0] wr_count;

  logic [3:0]  valid2;
  logic [31:0] data2;
  logic        full2;
  logic [3:0]  ready2;
  logic        wr_en2;
  logic [7:0]  din2;
  logic [3:0]  grant2;
  logic [15:0] cnt2;

  fifo_wr_arbiter #(.MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .valid(valid), .data_bus(data_bus), .ready(ready),
    .fifo_full(fifo_full), .wr_en(wr_en), .din(din), .grant(grant), .wr_count(wr_count)
  );

  fifo_wr_arbiter #(.MAX_BURST(16)) u_wrap (
    .clk(clk), .rst(rst), .valid(valid2), .data_bus(data2), .ready(ready2),
    .fifo_full(full2), .wr_en(wr_en2), .din(din2), .grant(grant2), .wr_count(cnt2)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic [3:0]  grant;
    logic [3:0]  ready;
    logic        wr_en;
    logic [7:0]  din;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] v, input logic [31:0] d, input logic f,
                              input logic [3:0] g, input logic [3:0] r, input logic w,
                              input logic [7:0] b, input logic [15:0] c);
    vec_t t;
    t.valid = v; t.data = d; t.full = f; t.grant = g;
    t.ready = r; t.wr_en = w; t.din = b; t.cnt = c;
    vq.push_back(t);
  endfunction

  // Called at a negedge; drives each vector for one cycle and checks before the next posedge
  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      valid     = vq[i].valid;
      data_bus  = vq[i].data;
      fifo_full = vq[i].full;
      #1;
      chk($sformatf("%s[%0d].grant", tag, i), 32'(grant), 32'(vq[i].grant));
      chk($sformatf("%s[%0d].ready", tag, i), 32'(ready), 32'(vq[i].ready));
      chk($sformatf("%s[%0d].wr_en", tag, i), 32'(wr_en), 32'(vq[i].wr_en));
      chk($sformatf("%s[%0d].din", tag, i), 32'(din), 32'(vq[i].din));
      chk($sformatf("%s[%0d].wr_count", tag, i), 32'(wr_count), 32'(vq[i].cnt));
      @(negedge clk);
    end
    vq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; valid = '0; data_bus = '0; fifo_full = 1'b0;
    valid2 = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b0; valid = '0; data_bus = '0; fifo_full = 1'b0;
    valid2 = '0; data2 = 32'h5A5A_5AE7; full2 = 1'b0;

    // Reset state
    #3;
    chk("reset.grant", 32'(grant), 32'h0);
    chk("reset.ready", 32'(ready), 32'h0);
    chk("reset.wr_en", 32'(wr_en), 32'h0);
    chk("reset.din", 32'(din), 32'h0);
    chk("reset.wr_count", 32'(wr_count), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single requester, 4+2 beats with one arbitration cycle in between
    add(4'b0001, {24'hDEADBE, 8'hA1}, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'd0);
    add(4'b0001, {24'hDEADBE, 8'hA1}, 0, 4'b0001, 4'b0001, 1, 8'hA1, 16'd0);
    add(4'b0001, {24'hDEADBE, 8'hA2}, 0, 4'b0001, 4'b0001, 1, 8'hA2, 16'd1);
    add(4'b0001, {24'hDEADBE, 8'hA3}, 0, 4'b0001, 4'b0001, 1, 8'hA3, 16'd2);
    add(4'b0001, {24'hDEADBE, 8'hA4}, 0, 4'b0001, 4'b0001, 1, 8'hA4, 16'd3);
    add(4'b0001, {24'hDEADBE, 8'hA5}, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'd4);
    add(4'b0001, {24'hDEADBE, 8'hA5}, 0, 4'b0001, 4'b0001, 1, 8'hA5, 16'd4);
    add(4'b0001, {24'hDEADBE, 8'hA6}, 0, 4'b0001, 4'b0001, 1, 8'hA6, 16'd5);
    add(4'b0000, {24'hDEADBE, 8'hA7}, 0, 4'b0001, 4'b0000, 0, 8'h00, 16'd6);
    add(4'b0000, {24'hDEADBE, 8'hA7}, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'd6);
    run_table("single");

    // Fair rotation with all four requesters valid
    do_reset();
    d = 32'h4433_2211;
    add(4'hF, d, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'd0);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++)
        add(4'hF, d, 0, 4'(1 << b), 4'(1 << b), 1, 8'(8'h11 * (b + 1)), 16'(4 * b + k));
      add(4'hF, d, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'(4 * (b + 1)));
    end
    add(4'hF, d, 0, 4'b0001, 4'b0001, 1, 8'h11, 16'd16);
    run_table("rotate");

    // FIFO full stall for 3 cycles on requester 2's second beat
    do_reset();
    add(4'b0100, {8'hEE, 8'hC1, 16'h5566}, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'd0);
    add(4'b0100, {8'hEE, 8'hC1, 16'h5566}, 0, 4'b0100, 4'b0100, 1, 8'hC1, 16'd0);
    add(4'b0100, {8'hEE, 8'hC2, 16'h5566}, 1, 4'b0100, 4'b0000, 0, 8'h00, 16'd1);
    add(4'b0100, {8'hEE, 8'hC2, 16'h5566}, 1, 4'b0100, 4'b0000, 0, 8'h00, 16'd1);
    add(4'b0100, {8'hEE, 8'hC2, 16'h5566}, 1, 4'b0100, 4'b0000, 0, 8'h00, 16'd1);
    add(4'b0100, {8'hEE, 8'hC2, 16'h5566}, 0, 4'b0100, 4'b0100, 1, 8'hC2, 16'd1);
    add(4'b0100, {8'hEE, 8'hC3, 16'h5566}, 0, 4'b0100, 4'b0100, 1, 8'hC3, 16'd2);
    add(4'b0100, {8'hEE, 8'hC4, 16'h5566}, 0, 4'b0100, 4'b0100, 1, 8'hC4, 16'd3);
    add(4'b0100, {8'hEE, 8'hC5, 16'h5566}, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'd4);
    run_table("stall");

    // Requester 1 releases early; requester 3 takes over after one idle cycle
    do_reset();
    d = 32'hD300_D100;
    add(4'b1010, d, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'd0);
    add(4'b1010, d, 0, 4'b0010, 4'b0010, 1, 8'hD1, 16'd0);
    add(4'b1010, d, 0, 4'b0010, 4'b0010, 1, 8'hD1, 16'd1);
    add(4'b1000, d, 0, 4'b0010, 4'b0000, 0, 8'h00, 16'd2);
    add(4'b1000, d, 0, 4'b0000, 4'b0000, 0, 8'h00, 16'd2);
    add(4'b1000, d, 0, 4'b1000, 4'b1000, 1, 8'hD3, 16'd2);
    add(4'b0000, d, 0, 4'b1000, 4'b0000, 0, 8'h00, 16'd3);
    run_table("release");

    // Asynchronous reset during requester 0's third beat
    do_reset();
    valid = 4'b0001; data_bus = 32'h0000_00B0;
    #1 chk("rstmid.idle_grant", 32'(grant), 32'h0);
    @(negedge clk); data_bus = 32'h0000_00B1;
    @(negedge clk); data_bus = 32'h0000_00B2;
    @(negedge clk); data_bus = 32'h0000_00B3;
    #1;
    chk("rstmid.beat3_wr_en", 32'(wr_en), 32'h1);
    chk("rstmid.beat3_din", 32'(din), 32'hB3);
    chk("rstmid.beat3_count", 32'(wr_count), 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("rstmid.wr_en", 32'(wr_en), 32'h0);
    chk("rstmid.ready", 32'(ready), 32'h0);
    chk("rstmid.grant", 32'(grant), 32'h0);
    chk("rstmid.din", 32'(din), 32'h0);
    chk("rstmid.wr_count", 32'(wr_count), 32'h0);
    @(negedge clk);
    chk("rstmid.held_count", 32'(wr_count), 32'h0);
    valid = 4'b1111;
    rst = 1'b1;
    #1 chk("rstmid.release_grant", 32'(grant), 32'h0);
    @(posedge clk); #1;
    chk("rstmid.first_grant", 32'(grant), 32'b0001);
    @(negedge clk);

    // Counter wrap on the MAX_BURST=16 instance: 65534 transfers need 69630 edges
    do_reset();
    valid2 = 4'b0001;
    repeat (69630) @(posedge clk);
    #1;
    chk("wrap.fffe", 32'(cnt2), 32'hFFFE);
    chk("wrap.fffe_wr_en", 32'(wr_en2), 32'h1);
    chk("wrap.din", 32'(din2), 32'hE7);
    @(posedge clk); #1;
    chk("wrap.ffff", 32'(cnt2), 32'hFFFF);
    @(posedge clk); #1;
    chk("wrap.0000", 32'(cnt2), 32'h0000);
    chk("wrap.idle_grant", 32'(grant2), 32'h0);
    @(posedge clk); #1;
    chk("wrap.regrant", 32'(grant2), 32'b0001);
    chk("wrap.hold_0000", 32'(cnt2), 32'h0000);
    @(posedge clk); #1;
    chk("wrap.0001", 32'(cnt2), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
